// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the multi-channel deserializer.
package deser_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } deser_state_e;

    // Bit counter must hold 0..WIDTH inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is not reset; dout is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/multichan_deserializer.sv
// NCH-lane serial-to-parallel converter with frame-sync alignment, output
// FIFO and sticky overflow/sync-error flags.
module multichan_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NCH       = 4,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic [NCH-1:0]       databits,
    input  logic                 frame_sync,
    input  logic                 clear_flags,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic                 overflow,
    output logic                 sync_err,
    output logic                 locked
);
    localparam int CW = cnt_width(WIDTH);

    deser_state_e                  state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d, cnt_base;
    logic [NCH-1:0][WIDTH-1:0]     shreg_q, shreg_sh;
    logic                          shift_en, push, pop;
    logic                          sync_err_set, overflow_set;
    logic                          overflow_q, sync_err_q;
    logic                          fifo_full, fifo_empty;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        if (MSB_FIRST) begin : g_msb
            assign shreg_sh[k] = {shreg_q[k][WIDTH-2:0], databits[k]};
        end else begin : g_lsb
            assign shreg_sh[k] = {databits[k], shreg_q[k][WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cnt_base     = cnt_q;
        shift_en     = 1'b0;
        push         = 1'b0;
        sync_err_set = 1'b0;
        case (state_q)
            HUNT: begin
                if (bit_valid && frame_sync) begin
                    state_d  = LOCKED;
                    shift_en = 1'b1;
                    cnt_d    = CW'(1);
                end
            end
            LOCKED: begin
                if (bit_valid) begin
                    shift_en = 1'b1;
                    // A sync slot always restarts the word; only mid-word is an error.
                    cnt_base     = frame_sync ? '0 : cnt_q;
                    sync_err_set = frame_sync && (cnt_q != '0);
                    if (cnt_base + CW'(1) == CW'(WIDTH)) begin
                        push  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_base + CW'(1);
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Every word is WIDTH full shifts, so stale bits never need clearing.
    always_ff @(posedge clk) begin
        if (rst)           shreg_q <= '0;
        else if (shift_en) shreg_q <= shreg_sh;
    end

    assign pop          = out_valid & out_ready;
    assign overflow_set = push & fifo_full & ~pop;

    sync_fifo #(
        .DW    (NCH*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (shreg_sh),
        .pop   (pop),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            overflow_q <= overflow_set | (overflow_q & ~clear_flags);
            sync_err_q <= sync_err_set | (sync_err_q & ~clear_flags);
        end
    end

    assign out_valid = ~fifo_empty;
    assign overflow  = overflow_q;
    assign sync_err  = sync_err_q;
    assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_multichan_deserializer.sv
// Scoreboard bench: two DUTs (MSB-first and LSB-first) share stimulus and are
// checked against a slot-level reference model.
module tb_multichan_deserializer;
    localparam int W  = 8;
    localparam int N  = 2;
    localparam int D  = 4;
    localparam int DW = N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bit_valid = 1'b0, frame_sync = 1'b0, clear_flags = 1'b0, out_ready = 1'b0;
    logic [N-1:0]  databits = '0;
    logic [DW-1:0] od0, od1;
    logic          ov0, ov1, of0, of1, se0, se1, lk0, lk1;

    always #5 clk = ~clk;

    multichan_deserializer #(.WIDTH(W), .NCH(N), .DEPTH(D), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .databits(databits),
        .frame_sync(frame_sync), .clear_flags(clear_flags), .out_valid(ov0),
        .out_ready(out_ready), .out_data(od0), .overflow(of0), .sync_err(se0), .locked(lk0));

    multichan_deserializer #(.WIDTH(W), .NCH(N), .DEPTH(D), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .databits(databits),
        .frame_sync(frame_sync), .clear_flags(clear_flags), .out_valid(ov1),
        .out_ready(out_ready), .out_data(od1), .overflow(of1), .sync_err(se1), .locked(lk1));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks lock, slot position in the word, FIFO occupancy and flags.
    bit            m_locked = 0;
    int            m_nb = 0;
    int            m_occ = 0;
    bit            m_ovf = 0, m_serr = 0;
    logic [N-1:0]  m_sb [W];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    bit            mon_en = 0;

    always @(posedge clk) begin
        logic [DW-1:0] w0, w1;
        bit            mpop, mpush, so, ss;
        if (rst) begin
            m_locked = 0; m_nb = 0; m_occ = 0; m_ovf = 0; m_serr = 0;
            q0.delete(); q1.delete();
        end else begin
            mpop = (m_occ > 0) && out_ready;
            mpush = 0; so = 0; ss = 0;
            if (bit_valid && (m_locked || frame_sync)) begin
                if (frame_sync) begin
                    if (m_locked && m_nb != 0) ss = 1;
                    m_nb = 0;
                end
                m_locked = 1;
                m_sb[m_nb] = databits;
                m_nb++;
                if (m_nb == W) begin
                    mpush = 1;
                    m_nb = 0;
                end
            end
            if (mpush) begin
                if (m_occ == D && !mpop) so = 1;
                else begin
                    w0 = '0; w1 = '0;
                    for (int k = 0; k < N; k++)
                        for (int i = 0; i < W; i++) begin
                            w0[k*W + (W-1-i)] = m_sb[i][k];
                            w1[k*W + i]       = m_sb[i][k];
                        end
                    q0.push_back(w0);
                    q1.push_back(w1);
                    m_occ++;
                end
            end
            if (mpop) m_occ--;
            m_ovf  = so ? 1'b1 : (clear_flags ? 1'b0 : m_ovf);
            m_serr = ss ? 1'b1 : (clear_flags ? 1'b0 : m_serr);
        end
    end

    // Monitor: compare at the falling edge, consume the head on a handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid0", ov0, m_occ > 0);
            chk("valid1", ov1, m_occ > 0);
            chk("locked0", lk0, m_locked);
            chk("locked1", lk1, m_locked);
            chk("overflow0", of0, m_ovf);
            chk("overflow1", of1, m_ovf);
            chk("sync_err0", se0, m_serr);
            chk("sync_err1", se1, m_serr);
            if (m_occ > 0 && q0.size() > 0) begin
                chk("data0", od0, q0[0]);
                chk("data1", od1, q1[0]);
                if (out_ready) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input bit fs, input logic [7:0] l0, input logic [7:0] l1, input bit rdy_last);
        for (int i = 0; i < W; i++) begin
            bit_valid  = 1'b1;
            frame_sync = fs && (i == 0);
            databits   = {l1[7-i], l0[7-i]};
            if (rdy_last && i == W-1) out_ready = 1'b1;
            step(1);
        end
        bit_valid  = 1'b0;
        frame_sync = 1'b0;
        if (rdy_last) out_ready = 1'b0;
    endtask

    task automatic raw_slots(input int n, input bit fs_first);
        for (int i = 0; i < n; i++) begin
            bit_valid  = 1'b1;
            frame_sync = fs_first && (i == 0);
            databits   = N'($urandom);
            step(1);
        end
        bit_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        step(2);
        mon_en = 1;
        chk("rst_data", od0, 16'h0000);
        chk("rst_valid", ov0, 1'b0);
        chk("rst_locked", lk0, 1'b0);
        rst = 1'b0;

        // Basic word, then a free-running second word without sync.
        send_word(1, 8'hA5, 8'h3C, 0);
        chk("s1_msb_word", od0, 16'h3CA5);
        chk("s1_valid", ov0, 1'b1);
        send_word(0, 8'h01, 8'h02, 0);
        out_ready = 1'b1;
        step(1);
        chk("s1_word2_msb", od0, 16'h0201);
        chk("s1_word2_lsb", od1, 16'h4080);
        step(2);
        out_ready = 1'b0;

        // Slots before any sync are ignored.
        reset_pulse();
        raw_slots(5, 0);
        chk("s2_hunt", lk0, 1'b0);
        send_word(1, 8'h5A, 8'hC3, 0);
        chk("s2_locked", lk0, 1'b1);
        chk("s2_one_word", od0, 16'hC35A);
        out_ready = 1'b1;
        step(2);
        chk("s2_drained", ov0, 1'b0);
        out_ready = 1'b0;

        // Sync with a partial word pending.
        raw_slots(3, 0);
        send_word(1, 8'hFF, 8'hFF, 0);
        chk("s3_sync_err", se0, 1'b1);
        chk("s3_word", od0, 16'hFFFF);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        chk("s3_cleared", se0, 1'b0);
        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;

        // Overflow with consumer stalled.
        reset_pulse();
        for (int v = 1; v <= 5; v++) send_word(v == 1, 8'(v), 8'(v), 0);
        chk("s4_overflow", of0, 1'b1);
        out_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            chk("s4_drain", od0, {8'(v), 8'(v)});
            step(1);
        end
        out_ready = 1'b0;
        chk("s4_empty", ov0, 1'b0);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;

        // Full FIFO with a pop coinciding with the completing push.
        for (int v = 1; v <= 4; v++) send_word(0, 8'(v), 8'(v), 0);
        send_word(0, 8'h05, 8'h05, 1);
        chk("s5_no_overflow", of0, 1'b0);
        out_ready = 1'b1;
        step(3);
        chk("s5_last_word", od0, 16'h0505);
        step(1);
        out_ready = 1'b0;

        // Reset mid-word with a queued word and a raised flag.
        send_word(0, 8'h11, 8'h22, 0);
        raw_slots(3, 0);
        raw_slots(4, 1);
        chk("s6_pre_err", se0, 1'b1);
        reset_pulse();
        chk("s6_valid", ov0, 1'b0);
        chk("s6_locked", lk0, 1'b0);
        chk("s6_sync_err", se0, 1'b0);
        chk("s6_overflow", of0, 1'b0);
        raw_slots(12, 0);
        chk("s6_ignored", ov0, 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            bit_valid   = ($urandom_range(0, 9) < 8);
            frame_sync  = ($urandom_range(0, 19) == 0);
            databits    = N'($urandom);
            out_ready   = ($urandom_range(0, 9) < 5);
            clear_flags = ($urandom_range(0, 29) == 0);
            rst         = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst = 1'b0; bit_valid = 1'b0; frame_sync = 1'b0; clear_flags = 1'b0;
        out_ready = 1'b1;
        step(8);
        chk("final_empty", ov0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
